// File: rtl/assoc_cache_pkg.sv
// cache_pkg: shared types and width helpers for the set-associative cache.
//   state_t   - cache controller FSM states
//   idx_bits  - set-index width for a given set count
//   tag_bits  - tag width for a given byte-address width and set count
//   age_bits  - per-way LRU age width for a given associativity
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR
    } state_t;

    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Two low address bits select a byte within the word and are not stored.
    function automatic int unsigned tag_bits(input int unsigned addr_width,
                                             input int unsigned sets);
        return addr_width - $clog2(sets) - 2;
    endfunction

    function automatic int unsigned age_bits(input int unsigned ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/assoc_cache_lru_ages.sv
// lru_ages: per-set LRU age storage with touch update and victim selection.
//   clk, rst_n  - clock, synchronous active-low reset (ages[w] = w in every set)
//   touch_en    - mark touch_way of set_sel as most recently used
//   set_sel     - set addressed by both the touch and the victim lookup
//   touch_way   - way being touched
//   valid_vec   - valid bits of set_sel, used to prefer invalid ways
//   victim_way  - lowest invalid way, else the way with the oldest age
module lru_ages
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned SETS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         touch_en,
    input  logic [idx_bits(SETS)-1:0]    set_sel,
    input  logic [age_bits(WAYS)-1:0]    touch_way,
    input  logic [WAYS-1:0]              valid_vec,
    output logic [age_bits(WAYS)-1:0]    victim_way
);

    localparam int unsigned AW = age_bits(WAYS);

    logic [AW-1:0] ages [SETS][WAYS];
    logic [AW-1:0] old_age;

    assign old_age = ages[set_sel][touch_way];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    ages[s][w] <= AW'(w);
                end
            end
        end else if (touch_en) begin
            // Ways younger than the touched one age by one; the permutation is preserved.
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (AW'(w) == touch_way) begin
                    ages[set_sel][w] <= '0;
                end else if (ages[set_sel][w] < old_age) begin
                    ages[set_sel][w] <= ages[set_sel][w] + 1'b1;
                end
            end
        end
    end

    // The descending scan over invalid ways runs last so the lowest invalid way wins.
    always_comb begin
        victim_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (ages[set_sel][w] == AW'(WAYS - 1)) begin
                victim_way = AW'(w);
            end
        end
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!valid_vec[w-1]) begin
                victim_way = AW'(w - 1);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-through, one-word-per-line data cache.
//   clk, rst_n        - clock, synchronous active-low reset
//   cpu_req/cpu_we    - CPU access valid / write
//   cpu_addr          - byte address (bits [1:0] ignored)
//   cpu_wdata         - CPU write data
//   cpu_rdata         - read data (hit data, or fill data in the ack cycle)
//   cpu_stall         - hold the pipeline while a memory transaction is outstanding
//   mem_req/mem_we    - registered memory request / write flag
//   mem_addr          - latched word-aligned address
//   mem_wdata         - latched write data
//   mem_rdata/mem_ack - memory read data, single-cycle completion
// Read misses allocate into the LRU (or lowest invalid) way; writes never allocate.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int unsigned IW = idx_bits(SETS);
    localparam int unsigned TW = tag_bits(ADDR_WIDTH, SETS);
    localparam int unsigned AW = age_bits(WAYS);

    logic [WAYS-1:0]       valid    [SETS];
    logic [TW-1:0]         tag_arr  [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_arr [SETS][WAYS];

    state_t state, state_next;

    logic [IW-1:0]         lk_set;
    logic [TW-1:0]         lk_tag;
    logic [WAYS-1:0]       hit_vec;
    logic                  hit;
    logic [AW-1:0]         hit_way;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [AW-1:0]         victim_way;
    logic [AW-1:0]         touch_way;
    logic                  touch_en;
    logic                  fill_en;
    logic                  update_en;

    // In IDLE the live CPU address is looked up; otherwise the latched copy.
    always_comb begin
        if (state == IDLE) begin
            lk_set = cpu_addr[2 +: IW];
            lk_tag = cpu_addr[ADDR_WIDTH-1 -: TW];
        end else begin
            lk_set = mem_addr[2 +: IW];
            lk_tag = mem_addr[ADDR_WIDTH-1 -: TW];
        end
    end

    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[lk_set][w] && tag_arr[lk_set][w] == lk_tag) begin
                hit_vec[w] = 1'b1;
                hit_way    = AW'(w);
                hit_data   = data_arr[lk_set][w];
            end
        end
    end

    assign hit = |hit_vec;

    lru_ages #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch_en   (touch_en),
        .set_sel    (lk_set),
        .touch_way  (touch_way),
        .valid_vec  (valid[lk_set]),
        .victim_way (victim_way)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        touch_en   = 1'b0;
        touch_way  = hit_way;
        fill_en    = 1'b0;
        update_en  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall  = 1'b1;
                        state_next = WR;
                    end else if (hit) begin
                        cpu_rdata = hit_data;
                        touch_en  = 1'b1;
                    end else begin
                        cpu_stall  = 1'b1;
                        state_next = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                if (mem_ack) begin
                    fill_en    = 1'b1;
                    touch_en   = 1'b1;
                    touch_way  = victim_way;
                    cpu_rdata  = mem_rdata;
                    state_next = IDLE;
                end else begin
                    cpu_stall = 1'b1;
                end
            end
            WR: begin
                if (mem_ack) begin
                    if (hit) begin
                        update_en = 1'b1;
                        touch_en  = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    cpu_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE && state_next != IDLE) begin
            mem_req  <= 1'b1;
            mem_we   <= cpu_we;
            mem_addr <= cpu_addr & ~ADDR_WIDTH'(3);
            if (cpu_we) begin
                mem_wdata <= cpu_wdata;
            end
        end else if (state != IDLE && mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s] <= '0;
            end
        end else if (fill_en) begin
            valid[lk_set][victim_way] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (rst_n && fill_en) begin
            tag_arr[lk_set][victim_way]  <= lk_tag;
            data_arr[lk_set][victim_way] <= mem_rdata;
        end else if (rst_n && update_en) begin
            data_arr[lk_set][hit_way] <= mem_wdata;
        end
    end

endmodule
